// File: rtl/game_sequencer.sv
// game_sequencer: top-level snake game controller.
//   - Decodes PS/2 set-2 scan codes (F0 break prefix, E0 extended prefix
//     ignored) into W/A/S/D direction, Space and (optionally) P commands.
//   - Runs the IDLE/RUN/PAUSE/OVER state machine and emits start/step pulses.
//   - Buffers up to two direction turns, applying at most one per step.
//   - Tracks score and shortens the step interval on each food eaten.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   key, key_pressed  : scan code byte and its one-cycle strobe
//   snake_alive       : 0 signals a collision from the snake field
//   food_eaten        : one-cycle pulse from the snake field
//   start, step       : registered one-cycle pulses to the snake field
//   snake_dir         : 0=up 1=right 2=down 3=left
//   is_running        : high in RUN
//   game_over         : high in OVER
//   score             : food count, saturating at 255
// Optional feature macro: GAME_PAUSE_EN (P toggles RUN <-> PAUSE).
module game_sequencer #(
  parameter int TICK_CYCLES     = 12000000,
  parameter int MIN_TICK_CYCLES = 3000000,
  parameter int SPEEDUP_CYCLES  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       key_pressed,
  input  logic       snake_alive,
  input  logic       food_eaten,
  output logic       start,
  output logic       step,
  output logic [1:0] snake_dir,
  output logic       is_running,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam logic [CW-1:0] TICK_L = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] MIN_L  = CW'(MIN_TICK_CYCLES);
  localparam logic [CW-1:0] SPD_L  = CW'(SPEEDUP_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO    = CW'(2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] intv_q, intv_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    q0_q, q0_d, q1_q, q1_d;
  logic [1:0]    qn_q, qn_d;
  logic          brk_q, brk_d;
  logic [7:0]    score_q, score_d;
  logic          start_q, start_d;
  logic          step_q, step_d;
  logic          ign_q, ign_d;
  logic          run_q, run_d;
  logic          over_q, over_d;

  // Scan decode
  logic       kv_space, kv_dir;
  logic [1:0] kv_d;
`ifdef GAME_PAUSE_EN
  logic       kv_p;
`endif

  always_comb begin
    brk_d    = brk_q;
    kv_space = 1'b0;
    kv_dir   = 1'b0;
    kv_d     = 2'd0;
`ifdef GAME_PAUSE_EN
    kv_p     = 1'b0;
`endif
    // E0 is skipped entirely so an E0 F0 xx sequence still discards xx.
    if (key_pressed && key != 8'hE0) begin
      if (brk_q) brk_d = 1'b0;
      else if (key == 8'hF0) brk_d = 1'b1;
      else begin
        case (key)
          8'h1D: begin kv_dir = 1'b1; kv_d = 2'd0; end
          8'h23: begin kv_dir = 1'b1; kv_d = 2'd1; end
          8'h1B: begin kv_dir = 1'b1; kv_d = 2'd2; end
          8'h1C: begin kv_dir = 1'b1; kv_d = 2'd3; end
          8'h29: kv_space = 1'b1;
`ifdef GAME_PAUSE_EN
          8'h4D: kv_p = 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Main sequencing
  logic       wrap, pop_t, alive_chk;
  logic [1:0] ref_dir;
  logic [31:0] iv;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    intv_d  = intv_q;
    dir_d   = dir_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    qn_d    = qn_q;
    score_d = score_q;
    start_d = 1'b0;
    step_d  = 1'b0;
    ign_d   = start_q;
    ref_dir = dir_q;
    iv      = 32'(intv_q);
    // >= rather than == so a shortened interval wraps at once if overshot.
    wrap      = cnt_q >= intv_q - ONE;
    pop_t     = cnt_q == intv_q - TWO;
    // The field is still reinitialising on the start cycle and the next.
    alive_chk = !start_q && !ign_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (kv_space) begin
          state_d = S_RUN;
          start_d = 1'b1;
          cnt_d   = '0;
          score_d = 8'd0;
          intv_d  = TICK_L;
          dir_d   = 2'd1;
          qn_d    = 2'd0;
        end
      end
      S_RUN: begin
        if (!snake_alive && alive_chk) begin
          state_d = S_OVER;
`ifdef GAME_PAUSE_EN
        end else if (kv_p) begin
          state_d = S_PAUSE;
`endif
        end else begin
          if (wrap) begin
            cnt_d  = '0;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
          // Pop one cycle ahead so snake_dir is settled during step.
          if (pop_t && qn_q != 2'd0) begin
            dir_d = q0_q;
            q0_d  = q1_q;
            qn_d  = qn_q - 2'd1;
          end
          // Push is checked against the post-pop tail.
          ref_dir = (qn_d == 2'd0) ? dir_d : (qn_d == 2'd1) ? q0_d : q1_d;
          if (kv_dir && qn_d != 2'd2 && kv_d != ref_dir && kv_d != (ref_dir ^ 2'd2)) begin
            if (qn_d == 2'd0) q0_d = kv_d;
            else              q1_d = kv_d;
            qn_d = qn_d + 2'd1;
          end
        end
        // Food counts even on the cycle the snake dies.
        if (food_eaten) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          if (iv > 32'(MIN_TICK_CYCLES + SPEEDUP_CYCLES)) intv_d = intv_q - SPD_L;
          else                                             intv_d = MIN_L;
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (kv_p) state_d = S_RUN;
      end
`endif
      default: ;
    endcase

    run_d  = state_d == S_RUN;
    over_d = state_d == S_OVER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      intv_q  <= TICK_L;
      dir_q   <= 2'd1;
      q0_q    <= 2'd0;
      q1_q    <= 2'd0;
      qn_q    <= 2'd0;
      brk_q   <= 1'b0;
      score_q <= 8'd0;
      start_q <= 1'b0;
      step_q  <= 1'b0;
      ign_q   <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intv_q  <= intv_d;
      dir_q   <= dir_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qn_q    <= qn_d;
      brk_q   <= brk_d;
      score_q <= score_d;
      start_q <= start_d;
      step_q  <= step_d;
      ign_q   <= ign_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  assign start      = start_q;
  assign step       = step_q;
  assign snake_dir  = dir_q;
  assign is_running = run_q;
  assign game_over  = over_q;
  assign score      = score_q;

endmodule
